de2i_150_pcie_onchip_ram2p: RTL and testbench
=============================================

DE2I_150_PCIE_ONCHIP_RAM2P -- requirements
Module: de2i_150_pcie_onchip_ram2p

Interface
REQ-001 Parameter DATA_W, default 64, data width of both ports; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 14, word address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter READ_LATENCY, default 1, cycles from read acceptance to readdatavalid; legal values 1 or 2.
REQ-004 Parameter CLEAR_ON_RESET, default 1, 1 = zero-fill the whole array after reset release.
REQ-005 clk  in  1  single clock for both ports and all state.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 address / address2  in  ADDR_W  word address, port s1 / s2.
REQ-008 byteenable / byteenable2  in  DATA_W/8  write byte lanes.
REQ-009 chipselect / chipselect2  in  1  port select.
REQ-010 read / read2, write / write2  in  1  command strobes.
REQ-011 writedata / writedata2  in  DATA_W  write data.
REQ-012 readdata / readdata2  out  DATA_W  read data.
REQ-013 readdatavalid / readdatavalid2  out  1  read data valid strobe.
REQ-014 waitrequest / waitrequest2  out  1  command stall.
REQ-015 clear_req  in  1  single-cycle pulse requesting zero-fill.
REQ-016 clear_busy  out  1  zero-fill in progress.

Function
REQ-017 A command SHALL be accepted on a port when chipselect & (read | write) & !waitrequest on a rising clk edge.
REQ-018 If read and write are both high on one port, it SHALL be treated as a write only; no readdatavalid is produced.
REQ-019 An accepted write SHALL update only the bytes whose byteenable bit is 1; all-zero byteenable SHALL be accepted as a no-op.
REQ-020 An accepted read SHALL assert readdatavalid for exactly one cycle, exactly READ_LATENCY cycles after acceptance; back-to-back reads SHALL yield back-to-back valids.
REQ-021 readdata SHALL hold its last value while readdatavalid is low.
REQ-022 Both ports writing the same address in the same cycle: s1 SHALL be accepted, waitrequest2 SHALL be high that cycle, and s2 retries next cycle (final content = s2 data on its enabled bytes).
REQ-023 Writes to different addresses, or reads on any addresses, SHALL proceed on both ports in the same cycle with no stall.
REQ-024 Read on one port and write on the other to the same address in the same cycle: the read SHALL return the new data (written bytes merged over old bytes).
REQ-025 Read and write on the same port are sequential: a read accepted the cycle after a write to the same address SHALL return the written data.
REQ-026 State machine states: RESET, CLEAR, RUN.
REQ-027 RESET -> CLEAR on first clk after reset release if CLEAR_ON_RESET = 1, else RESET -> RUN.
REQ-028 CLEAR: writes zero to addresses 0..2**ADDR_W-1, one word per cycle, ascending; after the last address SHALL go to RUN; duration exactly 2**ADDR_W cycles.
REQ-029 In CLEAR, clear_busy, waitrequest and waitrequest2 SHALL be 1; clear_req SHALL be ignored.
REQ-030 In RUN, clear_req = 1 SHALL move to CLEAR next cycle; commands presented in the clear_req cycle SHALL still be accepted; reads already in flight SHALL complete with their correct (pre-clear) data.
REQ-031 The clear address counter SHALL be ADDR_W bits and SHALL not wrap into a second pass.

Reset
REQ-032 While reset is high: readdata/readdata2 = 0, readdatavalid/readdatavalid2 = 0, waitrequest/waitrequest2 = 1, clear_busy = 0, read pipeline flushed.
REQ-033 Reset asserted mid-CLEAR or mid-read SHALL abort immediately; pending reads SHALL never produce readdatavalid; clear restarts at address 0 after release.
REQ-034 Array contents SHALL not be altered by reset itself, only by CLEAR.

Verification
REQ-035 Reset release, ADDR_W=4, CLEAR_ON_RESET=1 -> clear_busy high exactly 16 cycles; then read all 16 addresses on s2 -> all 0.
REQ-036 s1 writes 0x1122334455667788 to addr 5 with byteenable 0x0F, over 0 -> s2 read addr 5 returns 0x0000000055667788, READ_LATENCY cycles later.
REQ-037 Same cycle: s1 writes A to addr 3, s2 writes B to addr 3 -> waitrequest2 high one cycle; subsequent read of addr 3 = B.
REQ-038 Same cycle: s1 writes 0xFF..FF to addr 7 (byteenable all 1), s2 reads addr 7 -> readdata2 = 0xFF..FF.
REQ-039 READ_LATENCY=2, 4 back-to-back s1 reads addr 0..3 -> readdatavalid high cycles 2..5 after first acceptance, data in order.
REQ-040 clear_req issued with a read in flight, then reset asserted mid-CLEAR -> read returns pre-clear data; after reset release clear restarts at address 0 and runs a full 2**ADDR_W cycles.

Source files
------------

// File: rtl/de2i_150_pcie_onchip_ram2p.sv
// Two-port on-chip RAM with byte enables, same-address write arbitration,
// cross-port read forwarding, 1/2-cycle read latency and a zero-fill engine.
module de2i_150_pcie_onchip_ram2p #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  input  logic [ADDR_W-1:0]   address2,
  input  logic [DATA_W/8-1:0] byteenable2,
  input  logic                chipselect2,
  input  logic                read2,
  input  logic                write2,
  input  logic [DATA_W-1:0]   writedata2,
  output logic [DATA_W-1:0]   readdata2,
  output logic                readdatavalid2,
  output logic                waitrequest2,
  input  logic                clear_req,
  output logic                clear_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_RESET,
    S_CLEAR,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_run;
  logic              w_clear;
  logic [ADDR_W-1:0] r_clr_addr;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]             w_wr_req;
  logic                   w_conflict;
  logic [1:0]             w_acc_wr;
  logic [1:0]             w_acc_rd;
  logic [DATA_W-1:0]      w_mask1;
  logic [DATA_W-1:0]      w_mask2;
  logic [1:0][DATA_W-1:0] w_rdat;

  logic [1:0]             w_fin_v;
  logic [1:0][DATA_W-1:0] w_fin_d;
  logic [1:0]             r_rv;
  logic [1:0][DATA_W-1:0] r_rd;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: boot, fill pass, then run until a clear request
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RESET: begin
        w_state_nxt = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      end
      S_CLEAR: begin
        if (&r_clr_addr) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (clear_req) begin
          w_state_nxt = S_CLEAR;
        end
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase
  end

  // State decode: only RUN accepts commands, only CLEAR fills
  always_comb begin
    w_run   = 1'b0;
    w_clear = 1'b0;
    unique case (r_state)
      S_CLEAR: w_clear = 1'b1;
      S_RUN:   w_run   = 1'b1;
      default: begin
      end
    endcase
  end

  assign clear_busy   = w_clear;
  assign waitrequest  = ~w_run;
  assign waitrequest2 = ~w_run | w_conflict;

  // Fill address: one word per cycle, held at zero outside CLEAR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (w_clear) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end else begin
      r_clr_addr <= '0;
    end
  end

  // Command acceptance; s1 wins a same-address write collision
  always_comb begin
    w_wr_req[0] = chipselect & write;
    w_wr_req[1] = chipselect2 & write2;
    w_conflict  = w_wr_req[0] & w_wr_req[1]
                & (address == address2);
    w_acc_wr[0] = w_run & w_wr_req[0];
    w_acc_wr[1] = w_run & w_wr_req[1] & ~w_conflict;
    w_acc_rd[0] = w_run & chipselect & read & ~write;
    w_acc_rd[1] = w_run & chipselect2 & read2 & ~write2;
  end

  // Byte-lane masks expanded to bit granularity
  always_comb begin
    w_mask1 = '0;
    w_mask2 = '0;
    for (int b = 0; b < BE_W; b++) begin
      w_mask1[b*8 +: 8] = {8{byteenable[b]}};
      w_mask2[b*8 +: 8] = {8{byteenable2[b]}};
    end
  end

  // Read data with the other port's same-cycle write merged in
  always_comb begin
    w_rdat[0] = r_mem[address];
    w_rdat[1] = r_mem[address2];
    if (w_acc_wr[1] && (address2 == address)) begin
      w_rdat[0] = (w_rdat[0] & ~w_mask2)
                | (writedata2 & w_mask2);
    end
    if (w_acc_wr[0] && (address == address2)) begin
      w_rdat[1] = (w_rdat[1] & ~w_mask1)
                | (writedata & w_mask1);
    end
  end

  // Array update; contents are never touched by reset itself
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_mem[r_clr_addr] <= '0;
    end else begin
      for (int b = 0; b < BE_W; b++) begin
        if (w_acc_wr[0] && byteenable[b]) begin
          r_mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
        end
        if (w_acc_wr[1] && byteenable2[b]) begin
          r_mem[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]             r_p_v;
      logic [1:0][DATA_W-1:0] r_p_d;

      // Extra stage; data is captured at acceptance so a fill cannot disturb it
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_p_v <= '0;
          r_p_d <= '0;
        end else begin
          r_p_v <= w_acc_rd;
          r_p_d <= w_rdat;
        end
      end

      assign w_fin_v = r_p_v;
      assign w_fin_d = r_p_d;
    end else begin : g_lat1
      assign w_fin_v = w_acc_rd;
      assign w_fin_d = w_rdat;
    end
  endgenerate

  // Output stage: valid is a one-cycle strobe, data holds between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rv <= '0;
      r_rd <= '0;
    end else begin
      r_rv <= w_fin_v;
      for (int p = 0; p < 2; p++) begin
        if (w_fin_v[p]) begin
          r_rd[p] <= w_fin_d[p];
        end
      end
    end
  end

  assign readdatavalid  = r_rv[0];
  assign readdatavalid2 = r_rv[1];
  assign readdata       = r_rd[0];
  assign readdata2      = r_rd[1];

endmodule

// File: tb/tb_de2i_150_pcie_onchip_ram2p.sv
// Bench for the two-port RAM: latency-1 and latency-2 copies share stimulus
// and are compared every cycle against a word-level reference model.
module tb_de2i_150_pcie_onchip_ram2p;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int BW = DW / 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_req = 1'b0;

  logic [1:0]          cs;
  logic [1:0]          rd;
  logic [1:0]          wr;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][BW-1:0]  be;
  logic [1:0][DW-1:0]  wd;

  logic [1:0][1:0][DW-1:0] rdat;
  logic [1:0][1:0]         rvld;
  logic [1:0][1:0]         wreq;
  logic [1:0]              busy;

  int n_vec = 0;
  int n_err = 0;

  int mode;
  int cidx;
  int cyc = 0;
  logic [DW-1:0] mem [N];
  logic          ring_v [2][2][4];
  logic [DW-1:0] ring_d [2][2][4];
  logic [DW-1:0] hold [2][2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    de2i_150_pcie_onchip_ram2p #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .READ_LATENCY(g + 1),
      .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .address(addr[0]),
      .byteenable(be[0]),
      .chipselect(cs[0]),
      .read(rd[0]),
      .write(wr[0]),
      .writedata(wd[0]),
      .readdata(rdat[g][0]),
      .readdatavalid(rvld[g][0]),
      .waitrequest(wreq[g][0]),
      .address2(addr[1]),
      .byteenable2(be[1]),
      .chipselect2(cs[1]),
      .read2(rd[1]),
      .write2(wr[1]),
      .writedata2(wd[1]),
      .readdata2(rdat[g][1]),
      .readdatavalid2(rvld[g][1]),
      .waitrequest2(wreq[g][1]),
      .clear_req(clear_req),
      .clear_busy(busy[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    cs = '0;
    rd = '0;
    wr = '0;
    addr = '0;
    be = '0;
    wd = '0;
    clear_req = 1'b0;
  endtask

  task automatic cmd(input int p, input logic r, input logic w,
                     input logic [AW-1:0] a, input logic [BW-1:0] b,
                     input logic [DW-1:0] d);
    cs[p] = 1'b1;
    rd[p] = r;
    wr[p] = w;
    addr[p] = a;
    be[p] = b;
    wd[p] = d;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) begin
      mode = 0;
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 2; p++) begin
          hold[l][p] = '0;
          for (int s = 0; s < 4; s++) begin
            ring_v[l][p][s] = 1'b0;
            ring_d[l][p][s] = '0;
          end
        end
    end
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [BW-1:0] b,
                     input logic [DW-1:0] d);
    for (int i = 0; i < BW; i++)
      if (b[i]) mem[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic model_edge();
    logic w0, w1, r0, r1;
    int s;
    s = cyc % 4;
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 2; p++)
        if (ring_v[l][p][s]) begin
          hold[l][p] = ring_d[l][p][s];
          ring_v[l][p][s] = 1'b0;
        end
    cyc++;
    if (reset) return;
    case (mode)
      0: begin
        mode = 1;
        cidx = 0;
      end
      1: begin
        mem[cidx] = '0;
        cidx++;
        if (cidx == N) mode = 2;
      end
      default: begin
        w0 = cs[0] && wr[0];
        r0 = cs[0] && rd[0] && !wr[0];
        w1 = cs[1] && wr[1] && !(w0 && addr[0] == addr[1]);
        r1 = cs[1] && rd[1] && !wr[1];
        if (w0) put(addr[0], be[0], wd[0]);
        if (w1) put(addr[1], be[1], wd[1]);
        for (int l = 0; l < 2; l++) begin
          if (r0) begin
            ring_v[l][0][(cyc + l) % 4] = 1'b1;
            ring_d[l][0][(cyc + l) % 4] = mem[addr[0]];
          end
          if (r1) begin
            ring_v[l][1][(cyc + l) % 4] = 1'b1;
            ring_d[l][1][(cyc + l) % 4] = mem[addr[1]];
          end
        end
        if (clear_req) begin
          mode = 1;
          cidx = 0;
        end
      end
    endcase
  endtask

  task automatic check_outs();
    logic conf;
    logic ew;
    int s;
    s = cyc % 4;
    conf = (mode == 2) && cs[0] && wr[0] && cs[1] && wr[1]
        && (addr[0] == addr[1]);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("vld_l%0d_p%0d", l + 1, p + 1),
            DW'(rvld[l][p]), DW'(ring_v[l][p][s]));
        chk($sformatf("dat_l%0d_p%0d", l + 1, p + 1), rdat[l][p],
            ring_v[l][p][s] ? ring_d[l][p][s] : hold[l][p]);
        ew = (mode != 2) || (p == 1 && conf);
        chk($sformatf("wrq_l%0d_p%0d", l + 1, p + 1),
            DW'(wreq[l][p]), DW'(ew));
      end
      chk($sformatf("busy_l%0d", l + 1), DW'(busy[l]), DW'(mode == 1));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_count(input string tag);
    int c0, c1;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (busy[0]) c0++;
      if (busy[1]) c1++;
    end
    chk({tag, "_l1"}, DW'(c0), DW'(N));
    chk({tag, "_l2"}, DW'(c1), DW'(N));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    set_reset(1'b0);
    #2;
    set_reset(1'b1);
    repeat (3) tick();
    @(posedge clk);
    model_edge();
    #1;
    set_reset(1'b0);
    clear_count("clr_len_boot");

    for (int a = 0; a < N; a++) begin
      idle();
      cmd(1, 1'b1, 1'b0, AW'(a), '0, '0);
      tick();
    end
    idle();
    repeat (3) tick();

    cmd(0, 1'b0, 1'b1, 4'd5, 8'h0F, 64'h1122334455667788);
    tick();
    idle();
    cmd(1, 1'b1, 1'b0, 4'd5, '0, '0);
    tick();
    idle();
    chk("byteen_l1", rdat[0][1], 64'h0000000055667788);
    tick();
    chk("byteen_l2", rdat[1][1], 64'h0000000055667788);
    tick();

    cmd(0, 1'b0, 1'b1, 4'd3, 8'hFF, 64'hAAAA0000AAAA0000);
    cmd(1, 1'b0, 1'b1, 4'd3, 8'hFF, 64'hBBBB1111BBBB1111);
    #1;
    chk("coll_wrq2", DW'(wreq[0][1]), DW'(1));
    tick();
    cs[0] = 1'b0;
    wr[0] = 1'b0;
    #1;
    chk("retry_wrq2", DW'(wreq[0][1]), DW'(0));
    tick();
    idle();
    cmd(1, 1'b1, 1'b0, 4'd3, '0, '0);
    tick();
    idle();
    chk("coll_final", rdat[0][1], 64'hBBBB1111BBBB1111);
    tick();

    cmd(0, 1'b0, 1'b1, 4'd7, 8'hFF, '1);
    cmd(1, 1'b1, 1'b0, 4'd7, '0, '0);
    tick();
    idle();
    chk("fwd_rw", rdat[0][1], '1);
    tick();

    for (int a = 0; a < 4; a++) begin
      idle();
      cmd(0, 1'b0, 1'b1, AW'(a), 8'hFF, 64'h0101_0000_0000_0000 * (a + 1));
      tick();
    end
    for (int a = 0; a < 4; a++) begin
      idle();
      cmd(0, 1'b1, 1'b0, AW'(a), '0, '0);
      tick();
    end
    idle();
    repeat (4) tick();

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        cs[p] = ($urandom % 4) != 0;
        rd[p] = $urandom % 2;
        wr[p] = $urandom % 2;
        addr[p] = AW'($urandom % N);
        be[p] = BW'($urandom);
        wd[p] = {$urandom, $urandom};
      end
      clear_req = ($urandom % 120) == 0;
      tick();
    end
    idle();
    repeat (20) tick();

    cmd(0, 1'b0, 1'b1, 4'd9, 8'hFF, 64'hCAFEF00D12345678);
    tick();
    idle();
    cmd(0, 1'b1, 1'b0, 4'd9, '0, '0);
    clear_req = 1'b1;
    tick();
    idle();
    chk("preclr_l1", rdat[0][0], 64'hCAFEF00D12345678);
    tick();
    chk("preclr_l2", rdat[1][0], 64'hCAFEF00D12345678);
    chk("clr_busy", DW'(busy[0]), DW'(1));
    repeat (4) tick();
    set_reset(1'b1);
    repeat (2) tick();
    set_reset(1'b0);
    clear_count("clr_len_restart");
    cmd(0, 1'b1, 1'b0, 4'd9, '0, '0);
    tick();
    idle();
    chk("cleared_9", rdat[0][0], '0);
    tick();

    cmd(0, 1'b0, 1'b1, 4'd2, 8'hFF, 64'h5A5A5A5A5A5A5A5A);
    tick();
    idle();
    cmd(0, 1'b1, 1'b0, 4'd2, '0, '0);
    tick();
    idle();
    set_reset(1'b1);
    #1;
    chk("rst_vld_l1", DW'(rvld[0][0]), DW'(0));
    repeat (3) tick();
    set_reset(1'b0);
    clear_count("clr_len_rdrst");
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
